// File: rtl/boot_loader.sv
// boot_loader: streams data then instruction words into two BRAM write ports, then releases the CPU.
// Define BOOT_LOADER_CHECKSUM_EN to verify a trailing 32-bit sum word before release.
module boot_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  d_count,
  input  logic [8:0]  i_count,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [9:0]  d_w_addr,
  output logic [31:0] d_w_dat,
  output logic        d_w_enb,
  output logic [9:0]  i_w_addr,
  output logic [31:0] i_w_dat,
  output logic        i_w_enb,
  output logic        pc_stall,
  output logic        i_r_enb,
  output logic        rd_enbl,
  output logic        d_bram_init_done,
  input  logic        stop,
  output logic        busy,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_I, CHECK, RUN, ERROR} state_t;
  state_t      r_state, w_next, w_after;
  logic [8:0]  r_d_cnt, r_i_cnt, w_d_clamp, w_i_clamp;
  logic [7:0]  r_idx;
  logic [9:0]  r_w_addr;
  logic [31:0] r_w_dat;
  logic        r_s_ready, r_d_w_enb, r_i_w_enb, w_xfer, w_last, w_loading, w_start;
  assign w_d_clamp = d_count > 9'd256 ? 9'd256 : d_count;
  assign w_i_clamp = i_count > 9'd256 ? 9'd256 : i_count;
  assign w_start   = r_state == IDLE && start;
  assign w_xfer    = s_valid && r_s_ready;
  assign w_loading = r_state == LOAD_D || r_state == LOAD_I;
  assign w_last    = {1'b0, r_idx} == (r_state == LOAD_D ? r_d_cnt : r_i_cnt) - 9'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  assign w_after = CHECK;
  assign err     = r_state == ERROR;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_sum <= '0;
    else if (w_start) r_sum <= '0;
    else if (w_xfer && w_loading) r_sum <= r_sum + s_data;
`else
  assign w_after = RUN;
  assign err     = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start) w_next = w_d_clamp != 0 ? LOAD_D : w_i_clamp != 0 ? LOAD_I : w_after;
      LOAD_D: if (w_xfer && w_last) w_next = r_i_cnt != 0 ? LOAD_I : w_after;
      LOAD_I: if (w_xfer && w_last) w_next = w_after;
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHECK:  if (w_xfer) w_next = s_data == r_sum ? RUN : ERROR;
`endif
      RUN:    if (stop) w_next = IDLE;
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b0;
      r_d_cnt   <= '0;
      r_i_cnt   <= '0;
      r_idx     <= '0;
      r_w_addr  <= '0;
      r_w_dat   <= '0;
      r_d_w_enb <= 1'b0;
      r_i_w_enb <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_s_ready <= w_next == LOAD_D || w_next == LOAD_I || w_next == CHECK;
      r_d_w_enb <= w_xfer && r_state == LOAD_D;
      r_i_w_enb <= w_xfer && r_state == LOAD_I;
      if (w_xfer && w_loading) begin
        r_w_addr <= {r_idx, 2'b00};
        r_w_dat  <= s_data;
        r_idx    <= w_last ? '0 : r_idx + 8'd1;
      end
      if (w_start) begin
        r_d_cnt <= w_d_clamp;
        r_i_cnt <= w_i_clamp;
        r_idx   <= '0;
      end
    end
  // Both write ports share one address/data register; the strobes select the target.
  assign s_ready          = r_s_ready;
  assign d_w_addr         = r_w_addr;
  assign d_w_dat          = r_w_dat;
  assign d_w_enb          = r_d_w_enb;
  assign i_w_addr         = r_w_addr;
  assign i_w_dat          = r_w_dat;
  assign i_w_enb          = r_i_w_enb;
  assign pc_stall         = r_state != RUN;
  assign i_r_enb          = r_state == RUN;
  assign rd_enbl          = r_state == RUN;
  assign d_bram_init_done = r_state == CHECK || r_state == RUN || r_state == ERROR;
  assign busy             = r_state == LOAD_D || r_state == LOAD_I || r_state == CHECK;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed loads with a write-strobe scoreboard for boot_loader.
module tb_boot_loader;
  logic        clk = 0, rst = 0, start = 0, s_valid = 0, stop = 0;
  logic [8:0]  d_count = 0, i_count = 0;
  logic [31:0] s_data = 0;
  logic        s_ready, d_w_enb, i_w_enb, pc_stall, i_r_enb, rd_enbl, d_bram_init_done, busy, err;
  logic [9:0]  d_w_addr, i_w_addr;
  logic [31:0] d_w_dat, i_w_dat;
  int          checks = 0, errors = 0, n_ticks = 0, load_ticks = 0;
  logic [9:0]  last_d_addr = 0;
  logic [41:0] dq[$], iq[$];

  boot_loader dut (
    .clk(clk), .rst(rst), .start(start), .d_count(d_count), .i_count(i_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .pc_stall(pc_stall), .i_r_enb(i_r_enb), .rd_enbl(rd_enbl),
    .d_bram_init_done(d_bram_init_done), .stop(stop), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [41:0] e;
    @(posedge clk);
    #1;
    n_ticks++;
    if (d_w_enb) begin
      if (dq.size() == 0) chk("d_extra_strobe", d_w_enb, 0);
      else begin
        e = dq.pop_front();
        chk("d_addr", d_w_addr, e[41:32]);
        chk("d_dat", d_w_dat, e[31:0]);
        last_d_addr = d_w_addr;
      end
    end
    if (i_w_enb) begin
      if (iq.size() == 0) chk("i_extra_strobe", i_w_enb, 0);
      else begin
        e = iq.pop_front();
        chk("i_addr", i_w_addr, e[41:32]);
        chk("i_dat", i_w_dat, e[31:0]);
      end
    end
  endtask

  task automatic send(input logic [31:0] w, input bit gap);
    int t = 0;
    s_valid = 1;
    s_data  = w;
    while (!s_ready && t < 50) begin tick(); t++; end
    if (t == 50) chk("ready_timeout", s_ready, 1);
    tick();
    s_valid = 0;
    if (gap) tick();
  endtask

  task automatic load(input int dc, input int ic, input int n, input logic [31:0] base,
                      input bit gap, input logic [31:0] bad);
    int dcl = dc > 256 ? 256 : dc;
    logic [31:0] sum = 0;
    for (int k = 0; k < n; k++) begin
      sum += base + k;
      if (k < dcl) dq.push_back({10'(4 * k), base + 32'(k)});
      else iq.push_back({10'(4 * (k - dcl)), base + 32'(k)});
    end
    d_count = 9'(dc);
    i_count = 9'(ic);
    start = 1;
    tick();
    start = 0;
    if (n > 0) begin
      chk("load_busy", busy, 1);
      chk("load_ready", s_ready, 1);
      chk("load_init_done", d_bram_init_done, 0);
      chk("load_pc_stall", pc_stall, 1);
    end
    n_ticks = 0;
    for (int k = 0; k < n; k++) send(base + k, gap);
    load_ticks = n_ticks;
`ifdef BOOT_LOADER_CHECKSUM_EN
    chk("check_busy", busy, 1);
    send(sum + bad, 0);
`endif
    chk("dq_empty", dq.size(), 0);
    chk("iq_empty", iq.size(), 0);
  endtask

  task automatic check_run();
    tick();
    chk("run_pc_stall", pc_stall, 0);
    chk("run_i_r_enb", i_r_enb, 1);
    chk("run_rd_enbl", rd_enbl, 1);
    chk("run_init_done", d_bram_init_done, 1);
    chk("run_busy", busy, 0);
    chk("run_ready", s_ready, 0);
    chk("run_err", err, 0);
  endtask

  task automatic do_stop();
    stop = 1;
    tick();
    stop = 0;
    chk("stop_pc_stall", pc_stall, 1);
    chk("stop_i_r_enb", i_r_enb, 0);
    chk("stop_init_done", d_bram_init_done, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_pc_stall", pc_stall, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_d_w_enb", d_w_enb, 0);
    chk("rst_i_w_enb", i_w_enb, 0);
    chk("rst_d_w_addr", d_w_addr, 0);
    chk("rst_d_w_dat", d_w_dat, 0);
    chk("rst_i_w_addr", i_w_addr, 0);
    chk("rst_i_r_enb", i_r_enb, 0);
    chk("rst_rd_enbl", rd_enbl, 0);
    chk("rst_init_done", d_bram_init_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1;
    tick();
    // Continuous 3 data + 5 instruction words
    load(3, 5, 8, 32'h10, 0, 0);
    chk("cont_ticks", load_ticks, 8);
    check_run();
    start = 1;
    tick();
    start = 0;
    chk("start_ignored_run", pc_stall, 0);
    do_stop();
    // Same load with s_valid low every other cycle
    load(3, 5, 8, 32'h10, 1, 0);
    chk("gap_ticks", load_ticks, 16);
    check_run();
    do_stop();
    // No data section
    load(0, 2, 2, 32'h20, 0, 0);
    check_run();
    do_stop();
    // Asynchronous reset in the middle of a data load
    dq.push_back({10'h000, 32'h30});
    dq.push_back({10'h004, 32'h31});
    d_count = 3;
    i_count = 1;
    start = 1;
    tick();
    start = 0;
    stop = 1;
    tick();
    stop = 0;
    chk("stop_ignored_busy", busy, 1);
    send(32'h30, 0);
    send(32'h31, 0);
    chk("pre_rst_strobe", d_w_enb, 1);
    #2 rst = 0;
    #1;
    check_reset_outputs();
    dq.delete();
    iq.delete();
    @(posedge clk);
    #1 rst = 1;
    load(1, 0, 1, 32'hAB, 0, 0);
    check_run();
    do_stop();
`ifdef BOOT_LOADER_CHECKSUM_EN
    load(3, 0, 3, 32'h1, 0, 0);
    check_run();
    do_stop();
    load(3, 0, 3, 32'h1, 0, 1);
    tick();
    chk("bad_sum_err", err, 1);
    chk("bad_sum_pc_stall", pc_stall, 1);
    start = 1;
    stop = 1;
    repeat (3) tick();
    start = 0;
    stop = 0;
    chk("err_held", err, 1);
    chk("err_pc_stall_held", pc_stall, 1);
    chk("err_init_done", d_bram_init_done, 1);
    #2 rst = 0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1;
`endif
    // Oversized data count clamps to 256 words
    load(300, 0, 256, 32'h1000, 0, 0);
    chk("last_addr", last_d_addr, 10'h3FC);
    check_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
